spi_tx_fifo: RTL and testbench

Synchronous transmit-data FIFO that answers the data-request handshake of the SPI master and SPI slave cores (`fifo_req_data` → `fifo_din`/`fifo_din_valid`, plus `fifo_empty`). A host writes words on a simple write port. The block buffers them and returns exactly one word per accepted request, one cycle after the request. It sits between the host logic and the SPI core in both the master and slave builds.

---
 rtl/spi_tx_fifo.sv | 94 +++++++++
 tb/tb_spi_tx_fifo.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_fifo.sv
// spi_tx_fifo: transmit-data FIFO feeding the SPI master/slave core.
// The host pushes words on a write port. The SPI core pulls one word per
// accepted request, and the word is returned one cycle after the request.
module spi_tx_fifo #(
    parameter int data_width_g = 8,
    parameter int depth_g      = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_en,
    input  logic [data_width_g-1:0]      wr_data,
    output logic                         full,
    output logic                         overflow,
    output logic [$clog2(depth_g):0]     used,
    input  logic                         fifo_req_data,
    output logic [data_width_g-1:0]      fifo_din,
    output logic                         fifo_din_valid,
    output logic                         fifo_empty,
    output logic                         underflow
);

    localparam int AW = $clog2(depth_g);
    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(depth_g);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    logic [data_width_g-1:0] r_mem [depth_g];
    logic [AW-1:0]           r_wr_ptr;
    logic [AW-1:0]           r_rd_ptr;
    logic [AW:0]             r_used;
    logic                    r_full;
    logic                    r_empty;
    logic [data_width_g-1:0] r_dout;
    logic                    r_dvalid;
    logic                    r_ovf;
    logic                    r_udf;

    logic                    w_wr_acc;
    logic                    w_rd_acc;
    logic [AW:0]             w_used_nxt;

    // Accept decisions use the registered (pre-edge) flags, so a read never
    // makes room for a write on the same edge and a write never bypasses to
    // a read on an empty FIFO.
    always_comb begin
        w_wr_acc   = wr_en & ~r_full;
        w_rd_acc   = fifo_req_data & ~r_empty;
        w_used_nxt = r_used + {{AW{1'b0}}, w_wr_acc} - {{AW{1'b0}}, w_rd_acc};
    end

    // Storage array; contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy, flags, registered read word and status pulses.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_used   <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_dout   <= '0;
            r_dvalid <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_dout   <= r_mem[r_rd_ptr];
            end
            r_dvalid <= w_rd_acc;
            r_ovf    <= wr_en & r_full;
            r_udf    <= fifo_req_data & r_empty;
            r_used   <= w_used_nxt;
            r_empty  <= (w_used_nxt == '0);
            r_full   <= (w_used_nxt == DEPTH_CNT);
        end
    end

    assign full           = r_full;
    assign overflow       = r_ovf;
    assign used           = r_used;
    assign fifo_din       = r_dout;
    assign fifo_din_valid = r_dvalid;
    assign fifo_empty     = r_empty;
    assign underflow      = r_udf;

endmodule

// File: tb/tb_spi_tx_fifo.sv
// Testbench for spi_tx_fifo: randomized and directed stimulus checked
// against a queue-based FIFO model.
module tb_spi_tx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          overflow;
    logic [4:0]    used;
    logic          fifo_req_data;
    logic [DW-1:0] fifo_din;
    logic          fifo_din_valid;
    logic          fifo_empty;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of stored words plus expected output registers.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_dout;
    logic          m_valid;
    logic          m_ovf;
    logic          m_udf;

    spi_tx_fifo #(.data_width_g(DW), .depth_g(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .overflow(overflow), .used(used),
        .fifo_req_data(fifo_req_data), .fifo_din(fifo_din),
        .fifo_din_valid(fifo_din_valid), .fifo_empty(fifo_empty),
        .underflow(underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_q.delete();
        m_dout  = '0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    // Drive one cycle of stimulus from a negedge, advance the model by the
    // FIFO rules, and return at the following negedge.
    task automatic step(input logic we, input logic [DW-1:0] wd, input logic req);
        bit was_full;
        bit was_empty;
        wr_en         = we;
        wr_data       = wd;
        fifo_req_data = req;
        was_full  = (m_q.size() == DEPTH);
        was_empty = (m_q.size() == 0);
        m_ovf   = we && was_full;
        m_udf   = req && was_empty;
        m_valid = req && !was_empty;
        if (m_valid) m_dout = m_q.pop_front();
        if (we && !was_full) m_q.push_back(wd);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; wr_en = 1'b0; wr_data = '0; fifo_req_data = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (fifo_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b want 1", fifo_empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", full); end
        checks++; if (used !== 5'd0) begin errors++; $display("FAIL reset_used got %0d want 0", used); end
        checks++; if (fifo_din_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", fifo_din_valid); end
        checks++; if (fifo_din !== 8'h00) begin errors++; $display("FAIL reset_din got %h want 00", fifo_din); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_pulses got %0b%0b want 00", overflow, underflow); end
        rst = 1'b1;
        step(1'b0, '0, 1'b0);
        checks++; if (fifo_empty !== 1'b1 || used !== 5'd0) begin errors++; $display("FAIL post_reset_idle got empty=%0b used=%0d want 1/0", fifo_empty, used); end
    endtask

    task automatic test_single();
        step(1'b1, 8'hA5, 1'b0);
        checks++; if (fifo_empty !== 1'b0 || used !== 5'd1) begin errors++; $display("FAIL single_after_write got empty=%0b used=%0d want 0/1", fifo_empty, used); end
        step(1'b0, '0, 1'b1);
        checks++; if (fifo_din_valid !== 1'b1 || fifo_din !== 8'hA5) begin errors++; $display("FAIL single_read got v=%0b d=%h want 1/a5", fifo_din_valid, fifo_din); end
        checks++; if (fifo_empty !== 1'b1 || used !== 5'd0) begin errors++; $display("FAIL single_empty got empty=%0b used=%0d want 1/0", fifo_empty, used); end
        step(1'b0, '0, 1'b0);
        checks++; if (fifo_din_valid !== 1'b0 || fifo_din !== 8'hA5) begin errors++; $display("FAIL single_hold got v=%0b d=%h want 0/a5", fifo_din_valid, fifo_din); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 17; i++) begin
            step(1'b1, 8'(i), 1'b0);
            checks++;
            if (full !== (i >= 15) || overflow !== (i == 16) || used !== 5'(m_q.size())) begin
                errors++;
                $display("FAIL fill_%0d got full=%0b ovf=%0b used=%0d want %0b/%0b/%0d",
                         i, full, overflow, used, (i >= 15), (i == 16), m_q.size());
            end
        end
        checks++; if (used !== 5'd16) begin errors++; $display("FAIL fill_used got %0d want 16", used); end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, '0, 1'b1);
            checks++;
            if (fifo_din_valid !== 1'b1 || fifo_din !== 8'(i)) begin
                errors++;
                $display("FAIL drain_%0d got v=%0b d=%h want 1/%h", i, fifo_din_valid, fifo_din, 8'(i));
            end
        end
        checks++; if (fifo_empty !== 1'b1 || full !== 1'b0 || used !== 5'd0) begin errors++; $display("FAIL drain_end got empty=%0b full=%0b used=%0d want 1/0/0", fifo_empty, full, used); end
    endtask

    task automatic test_wrap();
        int writes = 0;
        step(1'b1, 8'($urandom), 1'b0);
        while (writes < 40) begin
            bit we;
            bit rq;
            int sz = m_q.size();
            we = (sz < 3) ? 1'b1 : 1'($urandom_range(0, 1));
            rq = (sz > 1) ? 1'b1 : 1'($urandom_range(0, 1));
            if (sz == 3) we = 1'b0;
            if (sz == 1) rq = we;
            step(we, 8'($urandom), rq);
            if (we) writes++;
            checks++;
            if (fifo_din_valid !== m_valid || fifo_din !== m_dout || used !== 5'(m_q.size())) begin
                errors++;
                $display("FAIL wrap_%0d got v=%0b d=%h used=%0d want %0b/%h/%0d",
                         writes, fifo_din_valid, fifo_din, used, m_valid, m_dout, m_q.size());
            end
        end
        while (m_q.size() > 0) begin
            step(1'b0, '0, 1'b1);
            checks++;
            if (fifo_din_valid !== 1'b1 || fifo_din !== m_dout) begin
                errors++;
                $display("FAIL wrap_drain got v=%0b d=%h want 1/%h", fifo_din_valid, fifo_din, m_dout);
            end
        end
    endtask

    task automatic test_simultaneous();
        // One stored word: read returns it, the new word replaces it.
        step(1'b1, 8'h3C, 1'b0);
        step(1'b1, 8'hC3, 1'b1);
        checks++; if (fifo_din_valid !== 1'b1 || fifo_din !== 8'h3C || used !== 5'd1) begin errors++; $display("FAIL simul_used1 got v=%0b d=%h used=%0d want 1/3c/1", fifo_din_valid, fifo_din, used); end
        step(1'b0, '0, 1'b1);
        checks++; if (fifo_din !== 8'hC3 || fifo_empty !== 1'b1) begin errors++; $display("FAIL simul_used1_next got d=%h empty=%0b want c3/1", fifo_din, fifo_empty); end
        // Empty: request underflows, write is stored.
        step(1'b1, 8'h5A, 1'b1);
        checks++; if (underflow !== 1'b1 || fifo_din_valid !== 1'b0 || used !== 5'd1) begin errors++; $display("FAIL simul_used0 got udf=%0b v=%0b used=%0d want 1/0/1", underflow, fifo_din_valid, used); end
        step(1'b0, '0, 1'b0);
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL simul_udf_pulse got %0b want 0", underflow); end
        step(1'b0, '0, 1'b1);
        checks++; if (fifo_din_valid !== 1'b1 || fifo_din !== 8'h5A) begin errors++; $display("FAIL simul_used0_word got v=%0b d=%h want 1/5a", fifo_din_valid, fifo_din); end
        // Full: read frees an entry but the write is still dropped.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
        step(1'b1, 8'hEE, 1'b1);
        checks++; if (fifo_din_valid !== 1'b1 || fifo_din !== 8'h80 || overflow !== 1'b1 || used !== 5'd15 || full !== 1'b0) begin
            errors++; $display("FAIL simul_used16 got v=%0b d=%h ovf=%0b used=%0d full=%0b want 1/80/1/15/0", fifo_din_valid, fifo_din, overflow, used, full);
        end
        while (m_q.size() > 0) begin
            step(1'b0, '0, 1'b1);
            checks++; if (fifo_din !== m_dout || fifo_din_valid !== 1'b1) begin errors++; $display("FAIL simul_drain got d=%h want %h", fifo_din, m_dout); end
        end
        checks++; if (fifo_din !== 8'h8F || fifo_empty !== 1'b1) begin errors++; $display("FAIL simul_last got d=%h empty=%0b want 8f/1 (ee dropped)", fifo_din, fifo_empty); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom), 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b1, 8'h77, 1'b1);
        wr_en = 1'b0; fifo_req_data = 1'b0;
        checks++; if (fifo_din_valid !== 1'b1 || used !== 5'd4) begin errors++; $display("FAIL mid_before got v=%0b used=%0d want 1/4", fifo_din_valid, used); end
        #2 rst = 1'b0;
        model_reset();
        #1;
        checks++; if (fifo_din_valid !== 1'b0 || fifo_din !== 8'h00 || used !== 5'd0 || fifo_empty !== 1'b1 || full !== 1'b0) begin
            errors++; $display("FAIL mid_async got v=%0b d=%h used=%0d empty=%0b full=%0b want 0/00/0/1/0", fifo_din_valid, fifo_din, used, fifo_empty, full);
        end
        @(negedge clk);
        rst = 1'b1;
        step(1'b0, '0, 1'b1);
        checks++; if (underflow !== 1'b1 || fifo_din_valid !== 1'b0) begin errors++; $display("FAIL mid_after got udf=%0b v=%0b want 1/0", underflow, fifo_din_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_wrap();
        test_simultaneous();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule
